prescaled_counter: RTL and testbench

Parametrised prescaled up/down counter for the FABulous board user-design area, and the next generation of the free-running demo counter. It provides a programmable prescaler, count direction, parallel load and three terminal behaviours (wrap, saturate, one-shot), with single-cycle event pulses. The top-level wrapper maps its outputs onto `io_out` with `io_oeb` driven low for output pins.

---
 rtl/prescaled_counter_pkg.sv | 11 +
 rtl/prescale_tick.sv | 29 ++
 rtl/prescaled_counter.sv | 93 +++++++++
 tb/tb_prescaled_counter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/prescaled_counter_pkg.sv
// Shared constants for the prescaled up/down counter: terminal-mode encodings
// and the prescale limit the board wrapper uses by default.
package prescaled_counter_pkg;

  localparam logic [1:0] MODE_WRAP    = 2'd0;
  localparam logic [1:0] MODE_SAT     = 2'd1;
  localparam logic [1:0] MODE_ONESHOT = 2'd2;

  localparam int PS_LIMIT = 1000;

endpackage

// File: rtl/prescale_tick.sv
// Programmable prescaler: asserts adv for one cycle every ps_limit+1 enabled
// cycles. clr restarts the phase.
module prescale_tick #(
  parameter int PS_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                clr,
  input  logic [PS_WIDTH-1:0] ps_limit,
  output logic                adv
);

  logic [PS_WIDTH-1:0] ps;

  // >= so that lowering ps_limit below the current phase wraps immediately.
  assign adv = en && (ps >= ps_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ps <= '0;
    end else if (clr || adv) begin
      ps <= '0;
    end else if (en) begin
      ps <= ps + PS_WIDTH'(1);
    end
  end

endmodule

// File: rtl/prescaled_counter.sv
// Prescaled up/down counter with wrap, saturate and one-shot terminal modes.
// Optional compare flag is built only when PRESCALED_COUNTER_CMP_EN is defined.
module prescaled_counter
  import prescaled_counter_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int PS_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                dir,
  input  logic [1:0]          mode,
  input  logic [PS_WIDTH-1:0] ps_limit,
  input  logic                load,
  input  logic [WIDTH-1:0]    load_val,
  input  logic [WIDTH-1:0]    cmp_val,
  output logic [WIDTH-1:0]    count,
  output logic                tick,
  output logic                ovf,
  output logic                running,
  output logic                cmp_match
);

  logic             adv;
  logic             at_term;
  logic             expire;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] next_count;

  assign term       = dir ? '1 : '0;
  assign at_term    = (count == term);
  assign next_count = dir ? count + WIDTH'(1) : count - WIDTH'(1);
  assign expire     = adv && at_term && (mode == MODE_ONESHOT);

  prescale_tick #(
    .PS_WIDTH(PS_WIDTH)
  ) u_prescale (
    .clk      (clk),
    .rst      (rst),
    .en       (en & running),
    .clr      (load | expire),
    .ps_limit (ps_limit),
    .adv      (adv)
  );

  // load outranks adv; an advance on the same edge is dropped without a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      tick    <= 1'b0;
      ovf     <= 1'b0;
      running <= 1'b1;
    end else begin
      tick <= 1'b0;
      ovf  <= 1'b0;
      if (load) begin
        count   <= load_val;
        running <= 1'b1;
      end else if (adv) begin
        tick <= 1'b1;
        if (!at_term) begin
          count <= next_count;
        end else begin
          ovf <= 1'b1;
          case (mode)
            MODE_SAT:     count <= count;
            MODE_ONESHOT: begin
              count   <= load_val;
              running <= 1'b0;
            end
            default:      count <= next_count;
          endcase
        end
      end
    end
  end

`ifdef PRESCALED_COUNTER_CMP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_match <= 1'b0;
    end else begin
      cmp_match <= (count == cmp_val);
    end
  end
`else
  logic unused_cmp_val;
  assign unused_cmp_val = ^cmp_val;
  assign cmp_match      = 1'b0;
`endif

endmodule

// File: tb/tb_prescaled_counter.sv
// Directed bench for prescaled_counter (WIDTH=4): expected {ovf,count} pairs
// are queued as stimulus is issued and popped by a monitor on every tick.
module tb_prescaled_counter;
  import prescaled_counter_pkg::*;

  localparam int WIDTH    = 4;
  localparam int PS_WIDTH = 8;
  localparam int W        = WIDTH + 1;

`ifdef PRESCALED_COUNTER_CMP_EN
  localparam logic CMP_ON = 1'b1;
`else
  localparam logic CMP_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic                dir;
  logic [1:0]          mode;
  logic [PS_WIDTH-1:0] ps_limit;
  logic                load;
  logic [WIDTH-1:0]    load_val;
  logic [WIDTH-1:0]    cmp_val;
  logic [WIDTH-1:0]    count;
  logic                tick;
  logic                ovf;
  logic                running;
  logic                cmp_match;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  prescaled_counter #(
    .WIDTH    (WIDTH),
    .PS_WIDTH (PS_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .dir       (dir),
    .mode      (mode),
    .ps_limit  (ps_limit),
    .load      (load),
    .load_val  (load_val),
    .cmp_val   (cmp_val),
    .count     (count),
    .tick      (tick),
    .ovf       (ovf),
    .running   (running),
    .cmp_match (cmp_match)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    load     = 1'b1;
    load_val = v;
    step(1);
    load     = 1'b0;
  endtask

  task automatic push(input logic o, input logic [WIDTH-1:0] c);
    exp_q.push_back({o, c});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // scoreboard monitor: every tick must match the next queued {ovf,count}
  always @(negedge clk) begin
    if (!rst && tick) begin
      logic [W-1:0] e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_tick actual count=%0d ovf=%0b required no tick t=%0t",
                 count, ovf, $time);
      end else begin
        e = exp_q.pop_front();
        if ({ovf, count} !== e) begin
          bad++;
          $display("FAIL tick_value actual ovf=%0b count=%0d required ovf=%0b count=%0d t=%0t",
                   ovf, count, e[W-1], e[WIDTH-1:0], $time);
        end
      end
    end else if (!rst && ovf) begin
      total++;
      bad++;
      $display("FAIL ovf_without_tick actual ovf=1 required 0 t=%0t", $time);
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; dir = 1'b1; mode = MODE_WRAP; ps_limit = 8'd3;
    load = 1'b0; load_val = '0; cmp_val = 4'd5;
    step(2);
    chk("rst_count",   32'(count),     0);
    chk("rst_tick",    32'(tick),      0);
    chk("rst_ovf",     32'(ovf),       0);
    chk("rst_running", 32'(running),   1);
    chk("rst_cmp",     32'(cmp_match), 0);

    // reset wrap: first advance on edge 4, then every 4 cycles
    for (int i = 1; i <= 5; i++) push(1'b0, 4'(i));
    rst = 1'b0;
    step(3);
    chk("first_edge3", 32'(count), 0);
    step(1);
    chk("first_edge4", 32'(count), 1);
    step(16);
    chk("count_after20", 32'(count), 5);
    en = 1'b0;

    // wrap up through 15 -> 0, ps_limit=0
    ps_limit = 8'd0; en = 1'b1;
    do_load(4'd14);
    push(1'b0, 4'd15); push(1'b1, 4'd0); push(1'b0, 4'd1);
    step(3);
    en = 1'b0;
    chk("wrap_up_count", 32'(count), 1);

    // wrap down through 0 -> 15
    dir = 1'b0; en = 1'b1;
    do_load(4'd1);
    push(1'b0, 4'd0); push(1'b1, 4'd15); push(1'b0, 4'd14);
    step(3);
    en = 1'b0;
    chk("wrap_dn_count", 32'(count), 14);

    // saturate up with ps_limit=1
    dir = 1'b1; mode = MODE_SAT; ps_limit = 8'd1; en = 1'b1;
    do_load(4'd14);
    push(1'b0, 4'd15); push(1'b1, 4'd15); push(1'b1, 4'd15);
    step(6);
    en = 1'b0;
    chk("sat_count",   32'(count),   15);
    chk("sat_running", 32'(running), 1);

    // one-shot down from 2
    dir = 1'b0; mode = MODE_ONESHOT; ps_limit = 8'd0; en = 1'b1;
    do_load(4'd2);
    push(1'b0, 4'd1); push(1'b0, 4'd0); push(1'b1, 4'd2);
    step(3);
    chk("os_running", 32'(running), 0);
    chk("os_count",   32'(count),   2);
    step(5);
    chk("os_idle_running", 32'(running), 0);
    chk("os_idle_count",   32'(count),   2);
    en = 1'b0;
    do_load(4'd6);
    chk("os_reload_running", 32'(running), 1);
    chk("os_reload_count",   32'(count),   6);
    chk("os_reload_tick",    32'(tick),    0);

    // load beats a coincident advance; lowering ps_limit forces an advance
    dir = 1'b1; mode = MODE_WRAP; ps_limit = 8'd3; en = 1'b1;
    do_load(4'd0);
    step(3);
    do_load(4'd9);
    chk("prio_count", 32'(count), 9);
    chk("prio_tick",  32'(tick),  0);
    ps_limit = 8'd10;
    step(7);
    ps_limit = 8'd2;
    push(1'b0, 4'd10);
    step(1);
    en = 1'b0;
    chk("limit_drop_count", 32'(count), 10);

    // compare flag
    ps_limit = 8'd0; en = 1'b1;
    do_load(4'd3);
    push(1'b0, 4'd4); push(1'b0, 4'd5); push(1'b0, 4'd6);
    step(1);
    chk("cmp_at4", 32'(cmp_match), 0);
    step(2);
    en = 1'b0;
    chk("cmp_after5", 32'(cmp_match), 32'(CMP_ON));
    step(1);
    chk("cmp_at6", 32'(cmp_match), 0);
    do_load(4'd5);
    step(1);
    chk("cmp_hold1", 32'(cmp_match), 32'(CMP_ON));
    step(1);
    chk("cmp_hold2", 32'(cmp_match), 32'(CMP_ON));

    // asynchronous reset mid-cycle
    rst = 1'b1;
    #1;
    chk("async_count",   32'(count),     0);
    chk("async_running", 32'(running),   1);
    chk("async_cmp",     32'(cmp_match), 0);
    step(1);
    rst = 1'b0;
    step(3);
    chk("missing_ticks", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
